// File: rtl/dtpu_pkg.sv
// Shared DTPU definitions: precision codes, load/store FSM state types and
// precision decode helpers used by the load/store pack unit.
package dtpu_pkg;

   localparam logic [3:0] PREC_8  = 4'b0001;
   localparam logic [3:0] PREC_16 = 4'b0011;
   localparam logic [3:0] PREC_32 = 4'b0111;
   localparam logic [3:0] PREC_64 = 4'b1111;

   typedef enum logic [1:0] {
      L_IDLE = 2'd0,
      L_CAP  = 2'd1,
      L_EMIT = 2'd2
   } ld_state_e;

   typedef enum logic {
      S_ACC   = 1'b0,
      S_WRITE = 1'b1
   } st_state_e;

   function automatic logic prec_legal(input logic [3:0] code);
      logic ok;
      case (code)
         PREC_8, PREC_16, PREC_32, PREC_64: ok = 1'b1;
         default:                           ok = 1'b0;
      endcase
      return ok;
   endfunction

   function automatic logic [8:0] elem_width(input logic [3:0] code);
      logic [8:0] w;
      case (code)
         PREC_8:  w = 9'd8;
         PREC_16: w = 9'd16;
         PREC_32: w = 9'd32;
         PREC_64: w = 9'd64;
         default: w = 9'd8;
      endcase
      return w;
   endfunction

   function automatic logic [2:0] elem_log2(input logic [3:0] code);
      logic [2:0] l;
      case (code)
         PREC_8:  l = 3'd3;
         PREC_16: l = 3'd4;
         PREC_32: l = 3'd5;
         PREC_64: l = 3'd6;
         default: l = 3'd3;
      endcase
      return l;
   endfunction

endpackage

// File: rtl/ls_unpacker.sv
// Load path: fetches one packed FIFO word at a time and hands it to the MXU
// as extended elements, lowest slot first.
module ls_unpacker
   import dtpu_pkg::*;
#(
   parameter int DATA_WIDTH = 64
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic [3:0]            i_data_precision,
   input  logic                  i_sign_ext,
   input  logic [DATA_WIDTH-1:0] i_fifo_rd_data,
   input  logic                  i_fifo_empty,
   output logic                  o_fifo_rd_en,
   output logic [DATA_WIDTH-1:0] o_ld_data,
   output logic                  o_ld_valid,
   input  logic                  i_ld_ready,
   output logic                  o_prec_err
);

   localparam int         CW = $clog2(DATA_WIDTH / 8);
   localparam logic [8:0] W9 = 9'(DATA_WIDTH);

   ld_state_e             r_state;
   ld_state_e             w_next;
   logic [CW-1:0]         r_cnt;
   logic [DATA_WIDTH-1:0] r_shreg;
   logic [3:0]            r_prec;
   logic                  r_sext;

   logic                  w_code_ok;
   logic                  w_rd;
   logic                  w_take;
   logic [8:0]            w_ew;
   logic [DATA_WIDTH-1:0] w_mask;
   logic [DATA_WIDTH-1:0] w_ext;
   logic [CW-1:0]         w_last_slot;

   // Datapath decode: read strobe, element extraction and extension.
   always_comb begin
      w_code_ok   = prec_legal(i_data_precision);
      w_rd        = !i_reset && (r_state == L_IDLE) && !i_fifo_empty && w_code_ok;
      w_take      = (r_state == L_EMIT) && i_ld_ready;
      w_ew        = elem_width(r_prec);
      w_mask      = {DATA_WIDTH{1'b1}} >> (W9 - w_ew);
      w_last_slot = CW'((W9 >> elem_log2(r_prec)) - 9'd1);
      // The element's sign bit is the top bit of the mask window.
      if (r_sext && (|(r_shreg & (w_mask ^ (w_mask >> 1))))) begin
         w_ext = (r_shreg & w_mask) | ~w_mask;
      end else begin
         w_ext = r_shreg & w_mask;
      end
      o_fifo_rd_en = w_rd;
      o_ld_valid   = !i_reset && (r_state == L_EMIT);
      o_ld_data    = w_ext;
      o_prec_err   = (r_state == L_IDLE) && !i_fifo_empty && !w_code_ok;
   end

   // Load FSM next-state logic.
   always_comb begin
      w_next = r_state;
      case (r_state)
         L_IDLE: begin
            if (w_rd) begin
               w_next = L_CAP;
            end else begin
               w_next = L_IDLE;
            end
         end
         L_CAP:  w_next = L_EMIT;
         L_EMIT: begin
            if (w_take && (r_cnt == {CW{1'b0}})) begin
               w_next = L_IDLE;
            end else begin
               w_next = L_EMIT;
            end
         end
         default: w_next = L_IDLE;
      endcase
   end

   // Load FSM state, per-word settings, shift register and slot counter.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state <= L_IDLE;
         r_cnt   <= {CW{1'b0}};
         r_shreg <= {DATA_WIDTH{1'b0}};
         r_prec  <= PREC_8;
         r_sext  <= 1'b0;
      end else begin
         r_state <= w_next;
         case (r_state)
            L_IDLE: begin
               if (w_rd) begin
                  r_prec <= i_data_precision;
                  r_sext <= i_sign_ext;
               end
            end
            L_CAP: begin
               r_shreg <= i_fifo_rd_data;
               r_cnt   <= w_last_slot;
            end
            L_EMIT: begin
               if (w_take) begin
                  r_shreg <= r_shreg >> w_ew;
                  if (r_cnt != {CW{1'b0}}) begin
                     r_cnt <= r_cnt - CW'(1'b1);
                  end
               end
            end
            default: r_state <= L_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/ls_pack_unit.sv
// Load/store unit between the DTPU data FIFOs and the MXU: unpacks FIFO words
// into elements (load) and packs MXU result elements into FIFO words (store).
module ls_pack_unit
   import dtpu_pkg::*;
#(
   parameter int DATA_WIDTH = 64
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [3:0]            data_precision,
   input  logic                  sign_ext,
   input  logic [DATA_WIDTH-1:0] fifo_rd_data,
   input  logic                  fifo_empty,
   output logic                  fifo_rd_en,
   output logic [DATA_WIDTH-1:0] mxu_ld_data,
   output logic                  mxu_ld_valid,
   input  logic                  mxu_ld_ready,
   input  logic [DATA_WIDTH-1:0] mxu_st_data,
   input  logic                  mxu_st_valid,
   input  logic                  mxu_st_last,
   output logic                  mxu_st_ready,
   output logic [DATA_WIDTH-1:0] fifo_wr_data,
   output logic                  fifo_wr_en,
   input  logic                  fifo_full,
   output logic                  prec_err
);

   localparam int         CW = $clog2(DATA_WIDTH / 8);
   localparam logic [8:0] W9 = 9'(DATA_WIDTH);

   logic                  w_ld_err;

   st_state_e             r_st_state;
   st_state_e             w_st_next;
   logic [CW-1:0]         r_idx;
   logic [DATA_WIDTH-1:0] r_acc;
   logic [3:0]            r_st_prec;
   logic                  r_prec_err;

   logic [3:0]            w_st_code;
   logic                  w_st_ok;
   logic [8:0]            w_st_ew;
   logic [DATA_WIDTH-1:0] w_st_mask;
   logic [8:0]            w_st_shamt;
   logic [CW-1:0]         w_st_last_slot;
   logic                  w_st_ready;
   logic                  w_st_take;
   logic                  w_st_flush;
   logic                  w_wr_en;
   logic                  w_st_err;

   ls_unpacker #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_unpacker (
      .i_clk            (clk),
      .i_reset          (reset),
      .i_data_precision (data_precision),
      .i_sign_ext       (sign_ext),
      .i_fifo_rd_data   (fifo_rd_data),
      .i_fifo_empty     (fifo_empty),
      .o_fifo_rd_en     (fifo_rd_en),
      .o_ld_data        (mxu_ld_data),
      .o_ld_valid       (mxu_ld_valid),
      .i_ld_ready       (mxu_ld_ready),
      .o_prec_err       (w_ld_err)
   );

   // Store decode: the first slot of a word uses the live code, later slots
   // use the code latched with that first element.
   always_comb begin
      w_st_code      = (r_idx == {CW{1'b0}}) ? data_precision : r_st_prec;
      w_st_ok        = prec_legal(w_st_code);
      w_st_ew        = elem_width(w_st_code);
      w_st_mask      = {DATA_WIDTH{1'b1}} >> (W9 - w_st_ew);
      w_st_shamt     = 9'(r_idx) << elem_log2(w_st_code);
      w_st_last_slot = CW'((W9 >> elem_log2(w_st_code)) - 9'd1);
      w_st_ready     = !reset && (r_st_state == S_ACC) && w_st_ok;
      w_st_take      = w_st_ready && mxu_st_valid;
      w_st_flush     = w_st_take && ((r_idx == w_st_last_slot) || mxu_st_last);
      w_wr_en        = !reset && (r_st_state == S_WRITE) && !fifo_full;
      w_st_err       = (r_st_state == S_ACC) && (r_idx == {CW{1'b0}}) &&
                       mxu_st_valid && !w_st_ok;
      mxu_st_ready   = w_st_ready;
      fifo_wr_en     = w_wr_en;
      fifo_wr_data   = r_acc;
      prec_err       = r_prec_err;
   end

   // Store FSM next-state logic.
   always_comb begin
      w_st_next = r_st_state;
      case (r_st_state)
         S_ACC: begin
            if (w_st_flush) begin
               w_st_next = S_WRITE;
            end else begin
               w_st_next = S_ACC;
            end
         end
         S_WRITE: begin
            if (w_wr_en) begin
               w_st_next = S_ACC;
            end else begin
               w_st_next = S_WRITE;
            end
         end
         default: w_st_next = S_ACC;
      endcase
   end

   // Store state, accumulator, slot index and the sticky precision error.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_st_state <= S_ACC;
         r_idx      <= {CW{1'b0}};
         r_acc      <= {DATA_WIDTH{1'b0}};
         r_st_prec  <= PREC_8;
         r_prec_err <= 1'b0;
      end else begin
         r_st_state <= w_st_next;
         if (w_st_take) begin
            if (r_idx == {CW{1'b0}}) begin
               r_st_prec <= data_precision;
            end
            r_acc <= r_acc | ((mxu_st_data & w_st_mask) << w_st_shamt);
            if (!w_st_flush) begin
               r_idx <= r_idx + CW'(1'b1);
            end
         end else if (w_wr_en) begin
            r_acc <= {DATA_WIDTH{1'b0}};
            r_idx <= {CW{1'b0}};
         end
         if (w_st_err || w_ld_err) begin
            r_prec_err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_ls_pack_unit.sv
// Directed bench for ls_pack_unit (DATA_WIDTH=64) with a queue-based model of
// element unpacking/packing and a per-cycle compare process.
module tb_ls_pack_unit;
   import dtpu_pkg::*;

   localparam int W = 64;

   logic         clk = 1'b0;
   logic         reset;
   logic [3:0]   data_precision;
   logic         sign_ext;
   logic [W-1:0] fifo_rd_data;
   logic         fifo_empty;
   logic         fifo_rd_en;
   logic [W-1:0] mxu_ld_data;
   logic         mxu_ld_valid;
   logic         mxu_ld_ready;
   logic [W-1:0] mxu_st_data;
   logic         mxu_st_valid;
   logic         mxu_st_last;
   logic         mxu_st_ready;
   logic [W-1:0] fifo_wr_data;
   logic         fifo_wr_en;
   logic         fifo_full;
   logic         prec_err;

   ls_pack_unit #(.DATA_WIDTH(W)) dut (
      .clk            (clk),
      .reset          (reset),
      .data_precision (data_precision),
      .sign_ext       (sign_ext),
      .fifo_rd_data   (fifo_rd_data),
      .fifo_empty     (fifo_empty),
      .fifo_rd_en     (fifo_rd_en),
      .mxu_ld_data    (mxu_ld_data),
      .mxu_ld_valid   (mxu_ld_valid),
      .mxu_ld_ready   (mxu_ld_ready),
      .mxu_st_data    (mxu_st_data),
      .mxu_st_valid   (mxu_st_valid),
      .mxu_st_last    (mxu_st_last),
      .mxu_st_ready   (mxu_st_ready),
      .fifo_wr_data   (fifo_wr_data),
      .fifo_wr_en     (fifo_wr_en),
      .fifo_full      (fifo_full),
      .prec_err       (prec_err)
   );

   always #5 clk = ~clk;

   int           checks = 0;
   int           errors = 0;
   int           cyc = 0;
   int           rd_cnt = 0;
   int           wr_cnt = 0;
   int           last_rd_cyc = 0;
   int           first_v_cyc = 0;
   int           st_e = 0;
   logic         prev_v = 1'b0;
   logic [W-1:0] last_wr = '0;
   logic [W-1:0] in_q[$];
   logic [W-1:0] exp_ld[$];
   logic [W-1:0] ld_log[$];
   logic [W-1:0] exp_wr[$];
   logic [W-1:0] st_list[$];

   function automatic int ew(input logic [3:0] p);
      case (p)
         4'b0001: return 8;
         4'b0011: return 16;
         4'b0111: return 32;
         4'b1111: return 64;
         default: return 0;
      endcase
   endfunction

   // Keep the low e bits of raw, optionally sign-extending from bit e-1.
   function automatic logic [W-1:0] ext(input logic [W-1:0] raw, input int e, input bit s);
      logic [W-1:0] m;
      logic [W-1:0] v;
      m = (e >= W) ? '1 : ((64'd1 << e) - 64'd1);
      v = raw & m;
      if (s && raw[e-1]) v = v | ~m;
      return v;
   endfunction

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Input FIFO: serves a word the cycle after each read strobe and queues
   // the elements that word must produce.
   initial begin : feeder
      logic [W-1:0] w;
      int           e;
      logic         rd;
      logic [3:0]   p;
      logic         s;
      fifo_empty   = 1'b1;
      fifo_rd_data = '0;
      forever begin
         @(negedge clk);
         rd = fifo_rd_en;
         p  = data_precision;
         s  = sign_ext;
         @(posedge clk);
         #1;
         if (rd && !reset && in_q.size() > 0) begin
            w = in_q.pop_front();
            fifo_rd_data = w;
            e = ew(p);
            if (e != 0) begin
               for (int i = 0; i < W / e; i++) exp_ld.push_back(ext(w >> (i * e), e, s));
            end
         end
         fifo_empty = (in_q.size() == 0);
      end
   end

   // Compare process: checks every handshake and strobe against the model.
   always @(negedge clk) begin : mon
      logic [W-1:0] word;
      cyc++;
      if (reset) begin
         exp_ld.delete();
         st_list.delete();
         exp_wr.delete();
         prev_v = 1'b0;
      end else begin
         if (fifo_rd_en) begin
            rd_cnt++;
            last_rd_cyc = cyc;
            chk("rd_en_while_empty", 64'(fifo_empty), 64'd0);
         end
         if (mxu_ld_valid) begin
            if (!prev_v) first_v_cyc = cyc;
            if (exp_ld.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL ld_unexpected actual=%h required=no_element", mxu_ld_data);
            end else begin
               chk("ld_data", mxu_ld_data, exp_ld[0]);
               if (mxu_ld_ready) begin
                  ld_log.push_back(mxu_ld_data);
                  void'(exp_ld.pop_front());
               end
            end
         end
         prev_v = mxu_ld_valid;
         if (fifo_wr_en) begin
            wr_cnt++;
            last_wr = fifo_wr_data;
            chk("wr_en_while_full", 64'(fifo_full), 64'd0);
            if (exp_wr.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL wr_unexpected actual=%h required=no_write", fifo_wr_data);
            end else begin
               chk("wr_data", fifo_wr_data, exp_wr.pop_front());
            end
         end
         if (mxu_st_valid && mxu_st_ready) begin
            if (st_list.size() == 0) st_e = ew(data_precision);
            if (st_e == 0) begin
               checks++;
               errors++;
               $display("FAIL st_illegal_accept actual=%h required=no_accept", data_precision);
            end else begin
               st_list.push_back(ext(mxu_st_data, st_e, 1'b0));
               if (st_list.size() == W / st_e || mxu_st_last) begin
                  word = '0;
                  for (int i = 0; i < st_list.size(); i++) word = word | (st_list[i] << (i * st_e));
                  exp_wr.push_back(word);
                  st_list.delete();
               end
            end
         end
      end
   end

   task automatic wait_ld(input string name);
      bit done;
      done = 1'b0;
      for (int k = 0; k < 200 && !done; k++) begin
         tick();
         if (in_q.size() == 0 && exp_ld.size() == 0 && !mxu_ld_valid && !fifo_rd_en) done = 1'b1;
      end
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL %s_timeout actual=pending required=drained", name);
      end
   endtask

   task automatic st_send(input logic [W-1:0] d, input logic l);
      bit ok;
      ok = 1'b0;
      mxu_st_valid = 1'b1;
      mxu_st_data  = d;
      mxu_st_last  = l;
      for (int k = 0; k < 40 && !ok; k++) begin
         @(negedge clk);
         if (mxu_st_ready) ok = 1'b1;
         @(posedge clk);
         #1;
      end
      mxu_st_valid = 1'b0;
      mxu_st_last  = 1'b0;
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL st_send_timeout actual=%h required=accepted", d);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_rd_en"},    64'(fifo_rd_en),   64'd0);
      chk({tag, "_ld_valid"}, 64'(mxu_ld_valid), 64'd0);
      chk({tag, "_ld_data"},  mxu_ld_data,       64'd0);
      chk({tag, "_st_ready"}, 64'(mxu_st_ready), 64'd0);
      chk({tag, "_wr_en"},    64'(fifo_wr_en),   64'd0);
      chk({tag, "_wr_data"},  fifo_wr_data,      64'd0);
      chk({tag, "_prec_err"}, 64'(prec_err),     64'd0);
   endtask

   initial begin : main
      int rd0;
      int wr0;
      reset          = 1'b1;
      data_precision = PREC_8;
      sign_ext       = 1'b0;
      mxu_ld_ready   = 1'b1;
      mxu_st_data    = '0;
      mxu_st_valid   = 1'b0;
      mxu_st_last    = 1'b0;
      fifo_full      = 1'b0;

      chk("model_sext8",  ext(64'h1FF80, 8, 1'b1), 64'hFFFF_FFFF_FFFF_FF80);
      chk("model_zext16", ext(64'hABCD8000, 16, 1'b0), 64'h8000);

      repeat (3) tick();
      chk_all_zero("reset");
      reset = 1'b0;
      tick();
      chk("st_ready_idle", 64'(mxu_st_ready), 64'd1);

      // 8-bit zero-extend load
      rd0 = rd_cnt;
      ld_log.delete();
      in_q.push_back(64'h8877665544332211);
      wait_ld("t_ld8");
      chk("ld8_count", 64'(ld_log.size()), 64'd8);
      for (int i = 0; i < 8; i++) chk("ld8_elem", ld_log[i], 64'(i + 1) * 64'h11);
      chk("ld8_reads", 64'(rd_cnt - rd0), 64'd1);
      chk("ld_latency", 64'(first_v_cyc - last_rd_cyc), 64'd2);

      // 16-bit sign-extend load
      data_precision = PREC_16;
      sign_ext = 1'b1;
      ld_log.delete();
      in_q.push_back(64'h0001_7FFF_8000_FFFF);
      wait_ld("t_ld16");
      chk("ld16_count", 64'(ld_log.size()), 64'd4);
      chk("ld16_e0", ld_log[0], 64'hFFFF_FFFF_FFFF_FFFF);
      chk("ld16_e1", ld_log[1], 64'hFFFF_FFFF_FFFF_8000);
      chk("ld16_e2", ld_log[2], 64'h0000_0000_0000_7FFF);
      chk("ld16_e3", ld_log[3], 64'h0000_0000_0000_0001);

      // 32-bit load with ready toggling every cycle
      data_precision = PREC_32;
      sign_ext = 1'b0;
      ld_log.delete();
      in_q.push_back(64'hDEADBEEF_12345678);
      in_q.push_back(64'h80000001_7FFFFFFE);
      for (int i = 0; i < 24; i++) begin
         mxu_ld_ready = ~mxu_ld_ready;
         tick();
      end
      mxu_ld_ready = 1'b1;
      wait_ld("t_bp");
      chk("bp_count", 64'(ld_log.size()), 64'd4);
      chk("bp_e0", ld_log[0], 64'h12345678);
      chk("bp_e1", ld_log[1], 64'hDEADBEEF);
      chk("bp_e2", ld_log[2], 64'h7FFFFFFE);
      chk("bp_e3", ld_log[3], 64'h80000001);

      // 32-bit store, upper bits of the element ignored
      wr0 = wr_cnt;
      st_send(64'hFFFF0000_AAAAAAAA, 1'b0);
      st_send(64'h00000000_BBBBBBBB, 1'b0);
      repeat (3) tick();
      chk("st32_word", last_wr, 64'hBBBBBBBB_AAAAAAAA);
      chk("st32_writes", 64'(wr_cnt - wr0), 64'd1);

      // 32-bit store held off by a full output FIFO
      fifo_full = 1'b1;
      st_send(64'h11111111, 1'b0);
      st_send(64'h22222222, 1'b0);
      for (int i = 0; i < 3; i++) begin
         chk("full_st_ready", 64'(mxu_st_ready), 64'd0);
         chk("full_wr_en", 64'(fifo_wr_en), 64'd0);
         tick();
      end
      fifo_full = 1'b0;
      #1;
      chk("full_release_wr_en", 64'(fifo_wr_en), 64'd1);
      tick();
      chk("full_after_st_ready", 64'(mxu_st_ready), 64'd1);
      chk("full_word", last_wr, 64'h22222222_11111111);

      // 8-bit partial flush, concurrent with an 8-bit load
      data_precision = PREC_8;
      ld_log.delete();
      in_q.push_back(64'h0807060504030201);
      fork
         wait_ld("t_conc");
         begin
            st_send(64'h01, 1'b0);
            st_send(64'h02, 1'b0);
            st_send(64'h03, 1'b1);
         end
      join
      tick();
      chk("flush_word", last_wr, 64'h0000000000030201);
      chk("conc_ld_count", 64'(ld_log.size()), 64'd8);

      // Illegal precision code, then recovery with 64-bit
      rd0 = rd_cnt;
      data_precision = 4'b0101;
      in_q.push_back(64'hCAFEF00D_01234567);
      repeat (5) tick();
      chk("illegal_no_read", 64'(rd_cnt - rd0), 64'd0);
      chk("illegal_prec_err", 64'(prec_err), 64'd1);
      mxu_st_valid = 1'b1;
      mxu_st_data  = 64'h5;
      tick();
      chk("illegal_st_ready", 64'(mxu_st_ready), 64'd0);
      mxu_st_valid = 1'b0;
      tick();
      ld_log.delete();
      data_precision = PREC_64;
      wait_ld("t_ld64");
      chk("ld64_count", 64'(ld_log.size()), 64'd1);
      chk("ld64_word", ld_log[0], 64'hCAFEF00D_01234567);
      chk("ld64_reads", 64'(rd_cnt - rd0), 64'd1);
      chk("prec_err_sticky", 64'(prec_err), 64'd1);

      // Reset in the middle of an 8-bit store word
      data_precision = PREC_8;
      wr0 = wr_cnt;
      st_send(64'hAA, 1'b0);
      st_send(64'hBB, 1'b0);
      reset = 1'b1;
      tick();
      chk_all_zero("midreset");
      reset = 1'b0;
      tick();
      chk("midreset_no_write", 64'(wr_cnt - wr0), 64'd0);
      st_send(64'h04, 1'b0);
      st_send(64'h05, 1'b0);
      st_send(64'h06, 1'b1);
      tick();
      chk("post_reset_word", last_wr, 64'h0000000000060504);
      chk("post_reset_writes", 64'(wr_cnt - wr0), 64'd1);

      repeat (2) tick();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
